// File: rtl/tlb_op_ctrl.sv
// TLB operation sequencer for TLBP / TLBR / TLBWI.
//
// Handshake: an operation is accepted on a rising edge where op_ready,
// op_valid and !flush are all high and op_type != 2'b00; op_ready is high
// only in IDLE, so the controller holds at most one operation at a time.
//
// At acceptance the CP0 fields are copied into a snapshot. Every TLB-facing
// output is driven from that snapshot, so MTC0 writes made while an
// operation is in flight have no effect on it. Strobes decode the
// registered state and are masked by flush in the same cycle.
//
// read_data carries the TLB read port back to CP0 while read_we is
// asserted. Its layout is {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}.
// It is zero in every other state.
//
// dbg_state shows the FSM state: 0 IDLE, 1 PROBE, 2 READ, 3 WRITE,
// 4 REFETCH, 5 DONE.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [31:0]      op_pc,
  output logic             op_ready,
  input  logic             flush,
  output logic             busy,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [18:0]      cp0_vpn2,
  input  logic [7:0]       cp0_asid,
  input  logic [19:0]      cp0_pfn0,
  input  logic [19:0]      cp0_pfn1,
  input  logic [2:0]       cp0_c0,
  input  logic [2:0]       cp0_c1,
  input  logic             cp0_d0,
  input  logic             cp0_v0,
  input  logic             cp0_g0,
  input  logic             cp0_d1,
  input  logic             cp0_v1,
  input  logic             cp0_g1,
  output logic [18:0]      s_vpn2,
  output logic [7:0]       s_asid,
  input  logic             s_found,
  input  logic [IDX_W-1:0] s_index,
  output logic [IDX_W-1:0] r_index,
  input  logic [18:0]      r_vpn2,
  input  logic [7:0]       r_asid,
  input  logic             r_g,
  input  logic [19:0]      r_pfn0,
  input  logic [2:0]       r_c0,
  input  logic             r_d0,
  input  logic             r_v0,
  input  logic [19:0]      r_pfn1,
  input  logic [2:0]       r_c1,
  input  logic             r_d1,
  input  logic             r_v1,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic [18:0]      w_vpn2,
  output logic [7:0]       w_asid,
  output logic             w_g,
  output logic [19:0]      w_pfn0,
  output logic [2:0]       w_c0,
  output logic             w_d0,
  output logic             w_v0,
  output logic [19:0]      w_pfn1,
  output logic [2:0]       w_c1,
  output logic             w_d1,
  output logic             w_v1,
  output logic             probe_we,
  output logic             probe_p,
  output logic [IDX_W-1:0] probe_index,
  output logic             read_we,
  output logic [77:0]      read_data,
  output logic             refetch_req,
  output logic [31:0]      refetch_pc,
  output logic             op_done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROBE   = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_REFETCH = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_snap_index;
  logic [18:0]      r_snap_vpn2;
  logic [7:0]       r_snap_asid;
  logic [19:0]      r_snap_pfn0;
  logic [19:0]      r_snap_pfn1;
  logic [2:0]       r_snap_c0;
  logic [2:0]       r_snap_c1;
  logic             r_snap_d0;
  logic             r_snap_v0;
  logic             r_snap_g0;
  logic             r_snap_d1;
  logic             r_snap_v1;
  logic             r_snap_g1;
  logic [31:0]      r_snap_npc;

  logic w_accept;
  logic w_in_probe;
  logic w_in_read;

  assign w_accept   = (r_state == S_IDLE) && op_valid && (op_type != 2'b00) && !flush;
  assign w_in_probe = (r_state == S_PROBE);
  assign w_in_read  = (r_state == S_READ);

  // Single FSM: accept with snapshot capture, one step per state, flush aborts to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_snap_index <= '0;
      r_snap_vpn2  <= '0;
      r_snap_asid  <= '0;
      r_snap_pfn0  <= '0;
      r_snap_pfn1  <= '0;
      r_snap_c0    <= '0;
      r_snap_c1    <= '0;
      r_snap_d0    <= 1'b0;
      r_snap_v0    <= 1'b0;
      r_snap_g0    <= 1'b0;
      r_snap_d1    <= 1'b0;
      r_snap_v1    <= 1'b0;
      r_snap_g1    <= 1'b0;
      r_snap_npc   <= '0;
    end else if ((r_state != S_IDLE) && flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_snap_index <= cp0_index;
            r_snap_vpn2  <= cp0_vpn2;
            r_snap_asid  <= cp0_asid;
            r_snap_pfn0  <= cp0_pfn0;
            r_snap_pfn1  <= cp0_pfn1;
            r_snap_c0    <= cp0_c0;
            r_snap_c1    <= cp0_c1;
            r_snap_d0    <= cp0_d0;
            r_snap_v0    <= cp0_v0;
            r_snap_g0    <= cp0_g0;
            r_snap_d1    <= cp0_d1;
            r_snap_v1    <= cp0_v1;
            r_snap_g1    <= cp0_g1;
            // Refetch target is precomputed so refetch_pc reads zero out of reset.
            r_snap_npc   <= op_pc + 32'd4;
            case (op_type)
              2'b01:   r_state <= S_PROBE;
              2'b10:   r_state <= S_READ;
              default: r_state <= S_WRITE;
            endcase
          end
        end
        S_PROBE:   r_state <= S_DONE;
        S_READ:    r_state <= S_REFETCH;
        S_WRITE:   r_state <= S_REFETCH;
        S_REFETCH: r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Status and strobes: state decodes, strobes masked by a same-cycle flush.
  assign dbg_state   = r_state;
  assign op_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign probe_we    = w_in_probe && !flush;
  assign read_we     = w_in_read && !flush;
  assign we          = (r_state == S_WRITE) && !flush;
  assign refetch_req = (r_state == S_REFETCH) && !flush;
  assign op_done     = (r_state == S_DONE) && !flush;

  // Probe result; the P bit and the index are meaningful only while probing.
  assign probe_p     = w_in_probe && !s_found;
  assign probe_index = (w_in_probe && s_found) ? s_index : '0;

  // TLB ports held at the snapshot value in every state.
  assign s_vpn2     = r_snap_vpn2;
  assign s_asid     = r_snap_asid;
  assign r_index    = r_snap_index;
  assign w_index    = r_snap_index;
  assign w_vpn2     = r_snap_vpn2;
  assign w_asid     = r_snap_asid;
  assign w_g        = r_snap_g0 & r_snap_g1;
  assign w_pfn0     = r_snap_pfn0;
  assign w_c0       = r_snap_c0;
  assign w_d0       = r_snap_d0;
  assign w_v0       = r_snap_v0;
  assign w_pfn1     = r_snap_pfn1;
  assign w_c1       = r_snap_c1;
  assign w_d1       = r_snap_d1;
  assign w_v1       = r_snap_v1;
  assign refetch_pc = r_snap_npc;

  // TLB read data is forwarded to CP0 while in READ, and is zero in every other state.
  assign read_data = w_in_read ? {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                                  r_pfn1, r_c1, r_d1, r_v1} : '0;

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the TLB-management instructions TLBP, TLBR and TLBWI. It accepts one operation at a time from the execute stage and takes a snapshot of the CP0 Index/EntryHi/EntryLo0/EntryLo1 fields. It then drives the TLB search, read or write port for exactly one cycle and returns the result to CP0 through dedicated write strobes. After TLBR or TLBWI it requests a pipeline refetch, so that instructions already fetched under the old mapping or ASID are replayed.

## Interface
- TLBNUM, 16: number of TLB entries.
- IDX_W, 4: index width, equal to log2(TLBNUM).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request from the execute stage.
- op_type  in  2  01 = TLBP, 10 = TLBR, 11 = TLBWI, 00 = none.
- op_pc  in  32  PC of the requesting instruction.
- op_ready  out  1  controller can accept an operation.
- flush  in  1  pipeline flush (exception or ERET).
- busy  out  1  high whenever the state is not IDLE.
- cp0_index  in  IDX_W  CP0 Index.index.
- cp0_vpn2  in  19  CP0 EntryHi.VPN2.
- cp0_asid  in  8  CP0 EntryHi.ASID.
- cp0_pfn0, cp0_pfn1  in  20 each  EntryLo0/1.PFN.
- cp0_c0, cp0_c1  in  3 each  EntryLo0/1.C.
- cp0_d0, cp0_v0, cp0_g0, cp0_d1, cp0_v1, cp0_g1  in  1 each  EntryLo0/1 D, V, G.
- s_vpn2  out  19  TLB search VPN2.
- s_asid  out  8  TLB search ASID.
- s_found  in  1  TLB search hit; combinational from s_vpn2/s_asid.
- s_index  in  IDX_W  TLB search hit index.
- r_index  out  IDX_W  TLB read index.
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  in  per field  TLB read data; combinational from r_index.
- we  out  1  TLB write strobe.
- w_index  out  IDX_W  TLB write index.
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out  per field  TLB write data.
- probe_we  out  1  strobe to CP0: update Index.P and Index.index.
- probe_p  out  1  value for Index.P; 1 = miss.
- probe_index  out  IDX_W  value for Index.index; valid on a hit only.
- read_we  out  1  strobe to CP0: load EntryHi/EntryLo0/EntryLo1 from the r_* fields; the r_* inputs are passed through to CP0.
- refetch_req  out  1  one-cycle pulse: refetch from refetch_pc.
- refetch_pc  out  32  op_pc + 4.
- op_done  out  1  one-cycle pulse: operation retired.

## Operation
- States: IDLE, PROBE, READ, WRITE, REFETCH, DONE. One-hot or encoded; the choice is free.
- IDLE:
  - op_ready = 1.
  - Acceptance requires op_valid & op_type != 00 & !flush.
  - On acceptance the controller registers op_type, op_pc and all cp0_* inputs into the snapshot.
  - Next state: PROBE (01), READ (10) or WRITE (11).
  - op_type 00 is ignored.
- PROBE:
  - s_vpn2/s_asid are driven from the snapshot. They are held at the snapshot value in every state.
  - probe_we = 1, probe_p = !s_found, probe_index = s_found ? s_index : 0.
  - Next state: DONE.
- READ:
  - r_index = snapshot index. It is held at the snapshot value in every state.
  - read_we = 1.
  - Next state: REFETCH.
- WRITE:
  - we = 1, w_index = snapshot index.
  - w_* fields come from the snapshot; w_g = g0 & g1.
  - w_* are held stable in every state.
  - Next state: REFETCH.
- REFETCH: refetch_req = 1, refetch_pc = snapshot op_pc + 4 (32-bit wrap). Next state: DONE.
- DONE: op_done = 1. Next state: IDLE.
- flush in any non-IDLE state:
  - Suppresses every strobe in that cycle: we, probe_we, read_we, refetch_req, op_done.
  - Next state: IDLE.
  - A flush arriving after WRITE has already committed does not undo the TLB write; only the refetch and op_done are dropped.
- The snapshot isolates the block from MTC0 writes to CP0 that occur during the operation.
- All strobes are registered-state decodes. A strobe never lasts more than one cycle per operation.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, snapshot = 0.
  - op_ready = 1, busy = 0.
  - we = probe_we = read_we = refetch_req = op_done = 0.
  - All index and data outputs = 0.
- Reset asserted mid-operation: immediate return to IDLE; no strobe is produced afterwards.
- Latency, with the accept edge at cycle T:
  - TLBP: probe_we at T+1, op_done at T+2.
  - TLBR: read_we at T+1, refetch_req at T+2, op_done at T+3.
  - TLBWI: we at T+1, refetch_req at T+2, op_done at T+3.
- Back-to-back operations: the next accept is possible in the cycle after DONE. Minimum spacing is 3 cycles for TLBP and 4 for TLBR/TLBWI.
- op_ready is 0 in every state except IDLE.

## Test plan
- Reset then TLBP, with entry 5 holding VPN2 0x12345 / ASID 0x3 and the snapshot matching → probe_we at T+1 with probe_p = 0, probe_index = 5; op_done at T+2; refetch_req stays 0.
- TLBP with no matching entry → probe_p = 1, probe_index = 0.
- TLBWI with index 7, pfn0 0xABCDE, g0 = 1, g1 = 0; MTC0 changes cp0_index to 2 at T+1 → we at T+1 with w_index = 7, w_pfn0 = 0xABCDE, w_g = 0; refetch_req at T+2 with op_pc 0xBFC00100 giving refetch_pc 0xBFC00104; op_done at T+3.
- TLBR of index 3 → read_we at T+1 carrying the TLB fields of entry 3; refetch_req at T+2; op_done at T+3.
- flush in the READ cycle → read_we, refetch_req and op_done all stay 0; op_ready = 1 at the next cycle. Also: flush coinciding with op_valid in IDLE → no accept.
- resetn pulsed low during the WRITE state of a TLBWI → we deasserts immediately, state = IDLE, no refetch_req or op_done follows.
